// File: rtl/if_stage.sv
// if_stage: fetch stage with one-outstanding req/gnt/rvalid port and a credit-limited queue to decode.
// FETCH_MISALIGN_CHK_EN adds inst_misalign; a misaligned redirect yields one flagged NOP and halts fetch.
module if_stage #(
   parameter logic [63:0] PC_RESET    = 64'h0000_0000_8000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [63:0] inst_addr,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic        inst_misalign,
`endif
   input  logic        id_ready
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_e;
   state_e        state_q, state_d;
   logic [63:0]   pc_q, pc_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wa;
   logic [PW:0]   cnt_q, cnt_d;
   logic          halt_q, halt_d;
   logic [31:0]   inst_mem [QUEUE_DEPTH];
   logic [63:0]   addr_mem [QUEUE_DEPTH];
   logic          gnt_ok, push, pop, mis_redir, we;
   logic [31:0]   wd_inst;
   logic [63:0]   wd_addr;
`ifdef FETCH_MISALIGN_CHK_EN
   logic          mis_mem [QUEUE_DEPTH];
   assign mis_redir     = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign inst_misalign = inst_valid && mis_mem[rd_q];
`else
   assign mis_redir = 1'b0;
`endif
   assign imem_req   = (state_q == REQ) && !halt_q && (cnt_q < DEPTH_C);
   assign imem_addr  = pc_q;
   assign gnt_ok     = imem_req && imem_gnt;
   assign push       = (state_q == WAIT) && imem_rvalid;
   assign inst_valid = cnt_q != '0;
   assign pop        = inst_valid && id_ready;
   assign inst       = inst_valid ? inst_mem[rd_q] : 32'h0;
   assign inst_addr  = inst_valid ? addr_mem[rd_q] : 64'h0;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      halt_d  = halt_q;
      we      = 1'b0;
      wa      = wr_q;
      wd_inst = imem_rdata;
      wd_addr = pc_q - 64'd4;
      if (redirect_valid) begin
         // Any response still owed by memory belongs to the wrong path and must be swallowed in FLUSH.
         pc_d    = redirect_pc & ~64'd3;
         halt_d  = mis_redir;
         rd_d    = '0;
         wr_d    = PW'(mis_redir);
         cnt_d   = (PW+1)'(mis_redir);
         we      = mis_redir;
         wa      = '0;
         wd_inst = 32'h0000_0013;
         wd_addr = redirect_pc;
         state_d = (state_q == WAIT || state_q == FLUSH) ? (imem_rvalid ? REQ : FLUSH)
                                                          : (gnt_ok ? FLUSH : REQ);
      end else begin
         pc_d    = gnt_ok ? pc_q + 64'd4 : pc_q;
         we      = push;
         wr_d    = push ? wr_q + 1'b1 : wr_q;
         rd_d    = pop ? rd_q + 1'b1 : rd_q;
         cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
         state_d = (state_q == IDLE) ? REQ :
                   (state_q == REQ)  ? (gnt_ok ? WAIT : REQ) :
                   imem_rvalid ? REQ : state_q;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= PC_RESET;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         halt_q  <= halt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (we) begin
         inst_mem[wa] <= wd_inst;
         addr_mem[wa] <= wd_addr;
`ifdef FETCH_MISALIGN_CHK_EN
         mis_mem[wa]  <= mis_redir;
`endif
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage; a memory model grants and answers fetches and
// records the words decode should receive, which a decode-side monitor checks in order.
module tb_if_stage;
   localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
   typedef struct {logic [63:0] addr; logic [31:0] inst; logic mis;} ent_t;
   logic        clk, rst, redirect_valid, imem_req, imem_gnt, imem_rvalid;
   logic        inst_valid, id_ready;
   logic [63:0] redirect_pc, imem_addr, inst_addr;
   logic [31:0] imem_rdata, inst;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        inst_misalign;
`endif
   ent_t        exp_q [$];
   ent_t        e;
   logic [63:0] nxt_pc, ga, s;
   int          n_cmp = 0, n_err = 0, gcount = 0, lat = 1;

   if_stage #(.PC_RESET(PC_RESET), .QUEUE_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr),
`ifdef FETCH_MISALIGN_CHK_EN
      .inst_misalign(inst_misalign),
`endif
      .id_ready(id_ready));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mdata(input logic [63:0] a);
      return {a[17:2], 16'h0513};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [63:0] pc);
      redirect_valid = 1;
      redirect_pc = pc;
      @(posedge clk);
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      if (pc[1:0] != 2'b00) exp_q.push_back('{pc, 32'h0000_0013, 1'b1});
`endif
      nxt_pc = pc & ~64'd3;
      #1 redirect_valid = 0;
   endtask

   task automatic wait_grant();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(imem_req && imem_gnt) && k < 30);
      chk("grant_seen", 64'(imem_req && imem_gnt), 64'd1);
   endtask

   // memory: grant is combinational from imem_gnt, response lat cycles after the grant
   initial begin
      imem_rvalid = 0;
      imem_rdata = 0;
      forever begin
         @(negedge clk);
         if (rst && imem_req && imem_gnt) begin
            ga = imem_addr;
            gcount++;
            chk("fetch_addr", ga, nxt_pc);
            nxt_pc = nxt_pc + 64'd4;
            exp_q.push_back('{ga, mdata(ga), 1'b0});
            repeat (lat) @(posedge clk);
            #1 imem_rvalid = 1;
            imem_rdata = mdata(ga);
            @(posedge clk);
            #1 imem_rvalid = 0;
            imem_rdata = 0;
         end
      end
   end

   // decode side: every accepted head must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk);
         if (rst && inst_valid && id_ready) begin
            if (exp_q.size() == 0) chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
            else begin
               e = exp_q.pop_front();
               chk("inst", 64'(inst), 64'(e.inst));
               chk("inst_addr", inst_addr, e.addr);
`ifdef FETCH_MISALIGN_CHK_EN
               chk("inst_misalign", 64'(inst_misalign), 64'(e.mis));
`endif
            end
         end else if (rst && !inst_valid) begin
            chk("idle_inst", 64'(inst), 64'd0);
            chk("idle_inst_addr", inst_addr, 64'd0);
         end
      end
   end

   initial begin
      rst = 0;
      redirect_valid = 0;
      redirect_pc = 0;
      imem_gnt = 0;
      id_ready = 0;
      nxt_pc = PC_RESET;
      repeat (2) @(negedge clk);
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_addr", imem_addr, PC_RESET);
      chk("rst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_inst_addr", inst_addr, 64'd0);
      tick();
      rst = 1;
      imem_gnt = 1;
      id_ready = 1;
      @(negedge clk);
      chk("idle_req", 64'(imem_req), 64'd0);
      tick();
      @(negedge clk);
      chk("first_req", 64'(imem_req), 64'd1);
      chk("first_addr", imem_addr, PC_RESET);
      tick();
      @(negedge clk);
      chk("lat_wait_valid", 64'(inst_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_valid", 64'(inst_valid), 64'd1);
      chk("lat_inst", 64'(inst), 64'h0000_0513);
      repeat (8) tick();
      imem_gnt = 0;
      repeat (4) tick();
      chk("drain1", 64'(exp_q.size()), 64'd0);
      s = nxt_pc;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req", 64'(imem_req), 64'd1);
         chk("stall_addr", imem_addr, s);
      end
      tick();
      gcount = 0;
      id_ready = 0;
      imem_gnt = 1;
      repeat (10) tick();
      @(negedge clk);
      chk("credit_grants", 64'(gcount), 64'd2);
      chk("credit_req", 64'(imem_req), 64'd0);
      chk("credit_head", inst_addr, s);
      tick();
      id_ready = 1;
      repeat (3) tick();
      chk("resume_addr_hi", 64'(gcount), 64'd3);
      repeat (6) tick();
      id_ready = 0;
      lat = 2;
      wait_grant();
      @(posedge clk);
      #1;
      redirect(64'h0000_0000_8000_1000);
      @(negedge clk);
      chk("wait_redir_valid", 64'(inst_valid), 64'd0);
      chk("wait_redir_req", 64'(imem_req), 64'd0);
      @(negedge clk);
      chk("wait_redir_req2", 64'(imem_req), 64'd1);
      chk("wait_redir_addr", imem_addr, 64'h0000_0000_8000_1000);
      tick();
      id_ready = 1;
      lat = 1;
      repeat (8) tick();
      wait_grant();
      redirect(64'h0000_0000_8000_2000);
      @(negedge clk);
      chk("gnt_redir_flush_req", 64'(imem_req), 64'd0);
      @(negedge clk);
      chk("gnt_redir_addr", imem_addr, 64'h0000_0000_8000_2000);
      repeat (6) tick();
`ifdef FETCH_MISALIGN_CHK_EN
      id_ready = 0;
      redirect(64'h0000_0000_8000_0002);
      gcount = 0;
      @(negedge clk);
      chk("mis_valid", 64'(inst_valid), 64'd1);
      chk("mis_inst", 64'(inst), 64'h13);
      chk("mis_addr", inst_addr, 64'h0000_0000_8000_0002);
      chk("mis_flag", 64'(inst_misalign), 64'd1);
      chk("mis_req", 64'(imem_req), 64'd0);
      tick();
      id_ready = 1;
      repeat (6) tick();
      @(negedge clk);
      chk("mis_halt_grants", 64'(gcount), 64'd0);
      chk("mis_halt_req", 64'(imem_req), 64'd0);
      tick();
      redirect(64'h0000_0000_8000_3000);
      wait_grant();
      chk("mis_resume_addr", imem_addr, 64'h0000_0000_8000_3000);
`else
      redirect(64'h0000_0000_8000_4002);
      wait_grant();
      chk("align_addr", imem_addr, 64'h0000_0000_8000_4000);
`endif
      repeat (6) tick();
      rst = 0;
      exp_q.delete();
      nxt_pc = PC_RESET;
      repeat (3) tick();
      @(negedge clk);
      chk("midrst_req", 64'(imem_req), 64'd0);
      chk("midrst_addr", imem_addr, PC_RESET);
      chk("midrst_valid", 64'(inst_valid), 64'd0);
      tick();
      rst = 1;
      repeat (8) tick();
      imem_gnt = 0;
      repeat (5) tick();
      chk("drain_end", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
